// File: rtl/alu_ex_stage.sv
// alu_ex_stage: execute stage of the pipelined MIPS datapath.
// Computes AND/OR/ADD/SUB/SLT in a single cycle. When ALU_MUL_EN is defined,
// op 1000 runs a 32-iteration shift-add multiply. Results go into an EX/MEM
// output register under a valid/ready handshake.
//
//   state | meaning
//   IDLE  | accepting ops; single-cycle ops load the output register
//   MUL   | iterative multiply in progress (ALU_MUL_EN only)
module alu_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  aluOp,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic [4:0]  inDest,
    input  logic        inRegWrite,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow,
    output logic        illegal,
    output logic [4:0]  outDest,
    output logic        outRegWrite
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
`endif

    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic        overflow_q, overflow_d;
    logic        illegal_q, illegal_d;
    logic [4:0]  out_dest_q, out_dest_d;
    logic        out_rw_q, out_rw_d;
    logic        out_valid_q, out_valid_d;

    logic [31:0] alu_res;
    logic        alu_ovf;
    logic        alu_ill;
    logic [31:0] sum;
    logic [31:0] diff;

    logic        out_free;
    logic        accept;
    logic        is_mul;
    logic        mul_busy;
    logic        mul_done;
    logic [31:0] mul_res;
    logic [4:0]  mul_dest;
    logic        mul_rw;

    // The output register may be (re)loaded when it is empty or draining this cycle.
    assign out_free = !out_valid_q || out_ready;
    assign in_ready = rst_n && !mul_busy && out_free;
    assign accept   = in_valid && in_ready;

`ifdef ALU_MUL_EN
    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  pend_dest_q, pend_dest_d;
    logic        pend_rw_q, pend_rw_d;
    logic [31:0] mul_step;
    logic        mul_last;

    assign is_mul   = (aluOp == OP_MUL);
    assign mul_busy = (state_q == S_MUL);
    // Only the low 32 product bits are kept, so a 32-bit multiplicand shifted left suffices.
    assign mul_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mul_last = mul_busy && (cnt_q == 5'd31);
    assign mul_done = mul_last && out_free;
    assign mul_res  = mul_step;
    assign mul_dest = pend_dest_q;
    assign mul_rw   = pend_rw_q;

    // Multiply sequencing: one shift-add per cycle, final step waits for a free output register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        pend_dest_d = pend_dest_q;
        pend_rw_d   = pend_rw_q;
        case (state_q)
            S_IDLE: begin
                if (accept && is_mul) begin
                    state_d     = S_MUL;
                    cnt_d       = 5'd0;
                    mcand_d     = opA;
                    mplier_d    = opB;
                    acc_d       = 32'd0;
                    pend_dest_d = inDest;
                    pend_rw_d   = inRegWrite;
                end
            end
            S_MUL: begin
                if (!mul_last) begin
                    acc_d    = mul_step;
                    mcand_d  = {mcand_q[30:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[31:1]};
                    cnt_d    = cnt_q + 5'd1;
                end else if (out_free) begin
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Multiplier state and datapath registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 5'd0;
            mcand_q     <= 32'd0;
            mplier_q    <= 32'd0;
            acc_q       <= 32'd0;
            pend_dest_q <= 5'd0;
            pend_rw_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            pend_dest_q <= pend_dest_d;
            pend_rw_q   <= pend_rw_d;
        end
    end
`else
    assign is_mul   = 1'b0;
    assign mul_busy = 1'b0;
    assign mul_done = 1'b0;
    assign mul_res  = 32'd0;
    assign mul_dest = 5'd0;
    assign mul_rw   = 1'b0;
`endif

    assign sum  = opA + opB;
    assign diff = opA - opB;

    // Single-cycle ALU: result, signed overflow and illegal-code decode.
    always_comb begin
        alu_res = 32'd0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (aluOp)
            OP_AND: alu_res = opA & opB;
            OP_OR:  alu_res = opA | opB;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (opA[31] == opB[31]) && (sum[31] != opA[31]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (opA[31] != opB[31]) && (diff[31] != opA[31]);
            end
            OP_SLT: alu_res = {31'd0, ($signed(opA) < $signed(opB))};
`ifdef ALU_MUL_EN
            OP_MUL: alu_ill = 1'b0;
`endif
            default: alu_ill = 1'b1;
        endcase
    end

    // Output register: load on single-cycle accept or multiply completion, else drain.
    always_comb begin
        result_d    = result_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        illegal_d   = illegal_q;
        out_dest_d  = out_dest_q;
        out_rw_d    = out_rw_q;
        out_valid_d = out_valid_q;
        if (accept && !is_mul) begin
            result_d    = alu_res;
            zero_d      = (alu_res == 32'd0);
            overflow_d  = alu_ovf;
            illegal_d   = alu_ill;
            out_dest_d  = inDest;
            out_rw_d    = inRegWrite && !alu_ill;
            out_valid_d = 1'b1;
        end else if (mul_done) begin
            result_d    = mul_res;
            zero_d      = (mul_res == 32'd0);
            overflow_d  = 1'b0;
            illegal_d   = 1'b0;
            out_dest_d  = mul_dest;
            out_rw_d    = mul_rw;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // EX/MEM boundary registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= 32'd0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            out_dest_q  <= 5'd0;
            out_rw_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            illegal_q   <= illegal_d;
            out_dest_q  <= out_dest_d;
            out_rw_q    <= out_rw_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign zero        = zero_q;
    assign overflow    = overflow_q;
    assign illegal     = illegal_q;
    assign outDest     = out_dest_q;
    assign outRegWrite = out_rw_q;

endmodule

// File: tb/tb_alu_ex_stage.sv
// tb_alu_ex_stage: directed and randomized checks of alu_ex_stage against a
// behavioural model. Honours ALU_MUL_EN the same way as the design.
module tb_alu_ex_stage;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam longint S32_MAX = 64'sd2147483647;
    localparam longint S32_MIN = -64'sd2147483648;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  aluOp;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [4:0]  inDest;
    logic        inRegWrite;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        illegal;
    logic [4:0]  outDest;
    logic        outRegWrite;

    int n_assert = 0;
    int n_fail   = 0;

    alu_ex_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .aluOp       (aluOp),
        .opA         (opA),
        .opB         (opB),
        .inDest      (inDest),
        .inRegWrite  (inRegWrite),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .overflow    (overflow),
        .illegal     (illegal),
        .outDest     (outDest),
        .outRegWrite (outRegWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference ALU from the arithmetic definitions (wide signed math).
    task automatic ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic ov, output logic il);
        longint sa;
        longint sb;
        longint t;
        sa = $signed(a);
        sb = $signed(b);
        r  = 32'd0;
        ov = 1'b0;
        il = 1'b0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin
                t  = sa + sb;
                r  = t[31:0];
                ov = (t > S32_MAX) || (t < S32_MIN);
            end
            4'd6: begin
                t  = sa - sb;
                r  = t[31:0];
                ov = (t > S32_MAX) || (t < S32_MIN);
            end
            4'd7: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd8: begin
                if (MUL_EN) r = a * b;
                else il = 1'b1;
            end
            default: il = 1'b1;
        endcase
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one op with out_ready=1, expect acceptance and the result one edge later.
    // in_valid is left high so callers can chain ops back-to-back.
    task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d, input logic rw);
        logic [31:0] r;
        logic        ov;
        logic        il;
        aluOp = op; opA = a; opB = b; inDest = d; inRegWrite = rw;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1);
        cyc();
        ref_alu(op, a, b, r, ov, il);
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_result"}, result, r);
        chk({tag, "_zero"}, zero, (r == 32'd0));
        chk({tag, "_overflow"}, overflow, ov);
        chk({tag, "_illegal"}, illegal, il);
        chk({tag, "_outDest"}, outDest, d);
        chk({tag, "_outRegWrite"}, outRegWrite, rw && !il);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0]  ops [8];
        logic        e_valid, e_ovf, e_ill, e_rw;
        logic [31:0] e_res;
        logic [4:0]  e_dest;
        int          mul_left;
        logic [31:0] p_res;
        logic [4:0]  p_dest;
        logic        p_rw;
        logic        exp_ir, acc;
        logic [31:0] r;
        logic        ov, il;
        logic        seen;
        int          n;

        ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd3, 4'd8, 4'd15};

        // Reset
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; aluOp = 4'd2;
        opA = 32'd1; opB = 32'd2; inDest = 5'd3; inRegWrite = 1'b1;
        #3;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_outDest", outDest, 0);
        chk("rst_outRegWrite", outRegWrite, 0);
        #19;
        in_valid = 1'b0;
        rst_n = 1'b1;
        cyc();
        chk("post_rst_out_valid", out_valid, 0);

        // Signed overflow on ADD
        single("add_ovf", 4'd2, 32'h7FFF_FFFF, 32'd1, 5'd4, 1'b1);
        chk("add_ovf_value", result, 32'h8000_0000);

        // SUB then SLT back-to-back
        single("sub_zero", 4'd6, 32'd5, 32'd5, 5'd5, 1'b1);
        chk("sub_zero_flag", zero, 1);
        single("slt_neg", 4'd7, 32'h8000_0000, 32'd1, 5'd6, 1'b1);
        chk("slt_neg_value", result, 32'd1);

        // AND with an output stall of three cycles
        single("and", 4'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd7, 1'b0);
        out_ready = 1'b0; aluOp = 4'd1; opA = 32'h1234_5678; opB = 32'd0;
        #1;
        chk("stall_in_ready0", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_out_valid", out_valid, 1);
            chk("stall_result", result, 32'h00F0_00F0);
            chk("stall_outDest", outDest, 7);
            chk("stall_in_ready", in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1);
        cyc();
        chk("release_out_valid", out_valid, 0);

        // Illegal op code
        single("illegal_0011", 4'd3, 32'h55, 32'hAA, 5'd8, 1'b1);
        chk("illegal_flag", illegal, 1);
        chk("illegal_rw", outRegWrite, 0);
        in_valid = 1'b0;
        cyc();

`ifdef ALU_MUL_EN
        // Iterative multiply: 32-cycle latency
        aluOp = 4'd8; opA = 32'h0001_0003; opB = 32'd5; inDest = 5'd9; inRegWrite = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("mul_in_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        n = 0; seen = 1'b0;
        while (!out_valid && n < 100) begin
            if (in_ready) seen = 1'b1;
            cyc();
            n++;
        end
        chk("mul_busy_in_ready", seen, 0);
        chk("mul_latency", n, 32);
        chk("mul_result", result, 32'h0005_000F);
        chk("mul_outDest", outDest, 9);
        chk("mul_rw", outRegWrite, 1);
        chk("mul_overflow", overflow, 0);
        cyc();

        // Reset during a second multiply
        aluOp = 4'd8; opA = 32'h0000_0007; opB = 32'h0000_0009; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        rst_n = 1'b0;
        #1;
        chk("mulrst_out_valid", out_valid, 0);
        chk("mulrst_in_ready_low", in_ready, 0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("mulrst_in_ready", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (out_valid) seen = 1'b1;
        end
        chk("mulrst_no_result", seen, 0);
`else
        single("mul_disabled", 4'd8, 32'h0001_0003, 32'd5, 5'd9, 1'b1);
        chk("mul_disabled_illegal", illegal, 1);
        in_valid = 1'b0;
        cyc();
`endif

        // Randomized traffic against the model
        in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        chk("rand_start_idle", out_valid, 0);
        e_valid = 1'b0; e_res = 0; e_ovf = 0; e_ill = 0; e_dest = 0; e_rw = 0;
        mul_left = 0; p_res = 0; p_dest = 0; p_rw = 0;
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            aluOp      = ops[$urandom_range(0, 7)];
            opA        = pick_operand();
            opB        = pick_operand();
            inDest     = 5'($urandom_range(0, 31));
            inRegWrite = 1'($urandom_range(0, 1));
            #1;
            exp_ir = (mul_left == 0) && (!e_valid || out_ready);
            chk("rand_in_ready", in_ready, exp_ir);
            acc = in_valid && exp_ir;
            if (mul_left > 1) begin
                mul_left--;
                if (out_ready) e_valid = 1'b0;
            end else if (mul_left == 1) begin
                if (!e_valid || out_ready) begin
                    e_valid = 1'b1; e_res = p_res; e_ovf = 1'b0; e_ill = 1'b0;
                    e_dest = p_dest; e_rw = p_rw; mul_left = 0;
                end
            end else if (acc && aluOp == 4'd8 && MUL_EN) begin
                ref_alu(aluOp, opA, opB, r, ov, il);
                p_res = r; p_dest = inDest; p_rw = inRegWrite;
                mul_left = 32;
                if (out_ready) e_valid = 1'b0;
            end else if (acc) begin
                ref_alu(aluOp, opA, opB, r, ov, il);
                e_valid = 1'b1; e_res = r; e_ovf = ov; e_ill = il;
                e_dest = inDest; e_rw = inRegWrite && !il;
            end else if (out_ready) begin
                e_valid = 1'b0;
            end
            cyc();
            chk("rand_out_valid", out_valid, e_valid);
            if (e_valid) begin
                chk("rand_result", result, e_res);
                chk("rand_zero", zero, (e_res == 32'd0));
                chk("rand_overflow", overflow, e_ovf);
                chk("rand_illegal", illegal, e_ill);
                chk("rand_outDest", outDest, e_dest);
                chk("rand_outRegWrite", outRegWrite, e_rw);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
